// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared widths and result record for the run-detect scheduler
package seq_det_pkg;

  localparam int MAX_CH_W  = 8;
  localparam int MAX_CNT_W = 8;

  function automatic int cnt_w(input int thresh);
    return (thresh < 1) ? 1 : $clog2(thresh + 1);
  endfunction

  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Widest-case record; users slice down to their own CH_W / CNT_W.
  typedef struct packed {
    logic [MAX_CH_W-1:0]  ch;
    logic [MAX_CNT_W-1:0] run;
    logic                 hit;
  } det_res_t;

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// rtl/seq_det_sched_rr_arbiter.sv - round-robin arbiter, one-hot grant plus index
module rr_arbiter
  import seq_det_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [ch_w(N)-1:0]   ptr,
  output logic [N-1:0]         gnt,
  output logic [ch_w(N)-1:0]   idx,
  output logic                 any
);

  localparam int IW = ch_w(N);

  logic [IW:0] pos;

  // Scan ptr, ptr+1, ... wrapping at N; first requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (IW + 1)'(i);
      if (pos >= (IW + 1)'(N)) begin
        pos = pos - (IW + 1)'(N);
      end
      if (!any && req[pos[IW-1:0]]) begin
        any            = 1'b1;
        gnt[pos[IW-1:0]] = 1'b1;
        idx            = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - one consecutive-ones run detector time-shared over NCH streams
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int THRESH = 3,
  parameter int HCNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            req_valid,
  input  logic [NCH-1:0]            req_bit,
  output logic [NCH-1:0]            req_ready,
  input  logic [NCH-1:0]            ctx_clr,
  output logic                      det_valid,
  input  logic                      det_ready,
  output logic [ch_w(NCH)-1:0]      det_ch,
  output logic                      det_hit,
  output logic [cnt_w(THRESH)-1:0]  det_run,
  output logic [HCNT_W-1:0]         hit_total
);

  localparam int CNT_W = cnt_w(THRESH);
  localparam int CH_W  = ch_w(NCH);
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

  logic [CNT_W-1:0]  run_q [NCH];
  logic [CH_W-1:0]   ptr_q;
  logic              valid_q;
  det_res_t          res_q;
  logic [HCNT_W-1:0] hit_q;

  logic              slot_free;
  logic [NCH-1:0]    arb_req;
  logic [NCH-1:0]    gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic [CNT_W-1:0]  run_cur;
  logic [CNT_W-1:0]  run_nxt;
  logic              hit_nxt;
  logic [CH_W-1:0]   ptr_nxt;

  assign slot_free = !valid_q || det_ready;
  assign arb_req   = slot_free ? req_valid : '0;

  rr_arbiter #(.N(NCH)) u_arb (
    .req (arb_req),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign req_ready = gnt;

  // A same-cycle clear on the granted channel restarts its run before the new bit.
  always_comb begin
    run_cur = ctx_clr[gnt_idx] ? '0 : run_q[gnt_idx];
    if (!req_bit[gnt_idx]) begin
      run_nxt = '0;
    end else if (run_cur >= THR) begin
      run_nxt = THR;
    end else begin
      run_nxt = run_cur + CNT_W'(1);
    end
    hit_nxt = (run_nxt >= THR);
    ptr_nxt = (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + CH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        run_q[i] <= '0;
      end
      ptr_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      hit_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ctx_clr[i]) begin
          run_q[i] <= '0;
        end
      end
      if (gnt_any) begin
        run_q[gnt_idx] <= run_nxt;
        ptr_q          <= ptr_nxt;
        valid_q        <= 1'b1;
        res_q.ch       <= MAX_CH_W'(gnt_idx);
        res_q.run      <= MAX_CNT_W'(run_nxt);
        res_q.hit      <= hit_nxt;
        if (hit_nxt && (hit_q != '1)) begin
          hit_q <= hit_q + HCNT_W'(1);
        end
      end else if (det_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign det_valid = valid_q;
  assign det_ch    = res_q.ch[CH_W-1:0];
  assign det_run   = res_q.run[CNT_W-1:0];
  assign det_hit   = res_q.hit;
  assign hit_total = hit_q;

  logic unused_res_bits;
  assign unused_res_bits = ^{res_q.ch[MAX_CH_W-1:CH_W], res_q.run[MAX_CNT_W-1:CNT_W]};

endmodule

// File: tb/tb_seq_det_sched.sv
// tb/tb_seq_det_sched.sv - directed and randomized bench for seq_det_sched
module tb_seq_det_sched;

  localparam int NCH    = 4;
  localparam int THRESH = 3;
  localparam int HCNT_W = 4;
  localparam int HMAX   = (1 << HCNT_W) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] req_valid, req_bit, req_ready, ctx_clr;
  logic           det_valid, det_ready, det_hit;
  logic [1:0]     det_ch;
  logic [1:0]     det_run;
  logic [HCNT_W-1:0] hit_total;

  int checks = 0;
  int passed = 0;

  int m_run [NCH];
  int m_ptr, m_ch, m_rout, m_tot;
  bit m_dv, m_hit;

  always #5 clk = ~clk;

  seq_det_sched #(.NCH(NCH), .THRESH(THRESH), .HCNT_W(HCNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_bit(req_bit), .req_ready(req_ready),
    .ctx_clr(ctx_clr),
    .det_valid(det_valid), .det_ready(det_ready),
    .det_ch(det_ch), .det_hit(det_hit), .det_run(det_run),
    .hit_total(hit_total)
  );

  function automatic logic [NCH-1:0] oh(input int g);
    logic [NCH-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic int m_grant(input logic [NCH-1:0] v, input logic rdy);
    if (m_dv && !rdy) return -1;
    for (int i = 0; i < NCH; i++) begin
      if (v[(m_ptr + i) % NCH]) return (m_ptr + i) % NCH;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) m_run[i] = 0;
    m_ptr = 0; m_dv = 0; m_ch = 0; m_rout = 0; m_hit = 0; m_tot = 0;
  endtask

  task automatic m_clock(input logic [NCH-1:0] b, c, input logic rdy, input int g);
    for (int i = 0; i < NCH; i++) if (c[i]) m_run[i] = 0;
    if (g >= 0) begin
      m_run[g] = b[g] ? ((m_run[g] + 1 > THRESH) ? THRESH : m_run[g] + 1) : 0;
      m_ptr  = (g + 1) % NCH;
      m_dv   = 1;
      m_ch   = g;
      m_rout = m_run[g];
      m_hit  = (m_rout >= THRESH);
      if (m_hit && m_tot < HMAX) m_tot++;
    end else if (rdy) begin
      m_dv = 0;
    end
  endtask

  task automatic tick(input logic [NCH-1:0] v, b, c, input logic rdy,
                      output logic [NCH-1:0] rr_obs, output int g_exp);
    req_valid = v; req_bit = b; ctx_clr = c; det_ready = rdy;
    #1;
    rr_obs = req_ready;
    g_exp  = m_grant(v, rdy);
    m_clock(b, c, rdy, g_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_bit = '0; ctx_clr = '0; det_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({det_valid, det_ch, det_hit, det_run, hit_total} !== '0) begin
      $display("FAIL reset_outputs got v=%0b ch=%0d hit=%0b run=%0d tot=%0d want all 0",
               det_valid, det_ch, det_hit, det_run, hit_total);
    end else passed++;
  endtask

  task automatic test_single_run();
    int exp_run [5] = '{1, 2, 3, 3, 0};
    bit exp_hit [5] = '{0, 0, 1, 1, 0};
    bit bits [5]    = '{1, 1, 1, 1, 0};
    logic [NCH-1:0] rr;
    int g;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(4'b0001, {3'b000, bits[i]}, '0, 1'b1, rr, g);
      checks++;
      if (rr !== 4'b0001) $display("FAIL single_grant[%0d] got %b want 0001", i, rr);
      else passed++;
      checks++;
      if (det_valid !== 1'b1 || det_ch !== 2'd0 || det_run !== 2'(exp_run[i]) || det_hit !== exp_hit[i])
        $display("FAIL single_result[%0d] got v=%0b ch=%0d run=%0d hit=%0b want v=1 ch=0 run=%0d hit=%0b",
                 i, det_valid, det_ch, det_run, det_hit, exp_run[i], exp_hit[i]);
      else passed++;
    end
    checks++;
    if (hit_total !== 4'd2) $display("FAIL single_hit_total got %0d want 2", hit_total);
    else passed++;
  endtask

  task automatic test_interleave();
    logic [NCH-1:0] rr;
    int g, er;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick('1, '1, '0, 1'b1, rr, g);
      er = (i / 4 + 1 > THRESH) ? THRESH : i / 4 + 1;
      checks++;
      if (rr !== oh(i % 4)) $display("FAIL interleave_grant[%0d] got %b want %b", i, rr, oh(i % 4));
      else passed++;
      checks++;
      if (det_ch !== 2'(i % 4) || det_run !== 2'(er) || det_hit !== (er >= THRESH))
        $display("FAIL interleave_result[%0d] got ch=%0d run=%0d hit=%0b want ch=%0d run=%0d hit=%0b",
                 i, det_ch, det_run, det_hit, i % 4, er, er >= THRESH);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [NCH-1:0] rr;
    int g;
    for (int i = 0; i < 3; i++) begin
      tick('1, '1, '0, 1'b0, rr, g);
      checks++;
      if (rr !== '0) $display("FAIL stall_ready[%0d] got %b want 0000", i, rr);
      else passed++;
      checks++;
      if (det_valid !== 1'b1 || det_ch !== 2'(m_ch) || det_run !== 2'(m_rout) || det_hit !== m_hit)
        $display("FAIL stall_hold[%0d] got v=%0b ch=%0d run=%0d hit=%0b want v=1 ch=%0d run=%0d hit=%0b",
                 i, det_valid, det_ch, det_run, det_hit, m_ch, m_rout, m_hit);
      else passed++;
    end
    tick('1, '1, '0, 1'b1, rr, g);
    checks++;
    if (rr !== oh(g) || g < 0) $display("FAIL release_grant got %b want %b", rr, oh(g));
    else passed++;
    checks++;
    if (det_valid !== 1'b1 || det_ch !== 2'(m_ch) || det_run !== 2'(m_rout))
      $display("FAIL release_result got v=%0b ch=%0d run=%0d want v=1 ch=%0d run=%0d",
               det_valid, det_ch, det_run, m_ch, m_rout);
    else passed++;
  endtask

  task automatic test_ctx_clr();
    logic [NCH-1:0] rr;
    int g;
    do_reset();
    tick(4'b0100, 4'b0100, '0, 1'b1, rr, g);
    tick(4'b0100, 4'b0100, '0, 1'b1, rr, g);
    tick(4'b0100, 4'b0100, 4'b0100, 1'b1, rr, g);
    checks++;
    if (det_ch !== 2'd2 || det_run !== 2'd1 || det_hit !== 1'b0)
      $display("FAIL clr_granted got ch=%0d run=%0d hit=%0b want ch=2 run=1 hit=0", det_ch, det_run, det_hit);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [NCH-1:0] rr;
    int g;
    do_reset();
    tick(4'b0010, 4'b0010, '0, 1'b1, rr, g);
    tick(4'b0010, 4'b0010, '0, 1'b1, rr, g);
    checks++;
    if (det_valid !== 1'b1 || det_run !== 2'd2)
      $display("FAIL pre_reset got v=%0b run=%0d want v=1 run=2", det_valid, det_run);
    else passed++;
    do_reset();
    checks++;
    if ({det_valid, det_ch, det_hit, det_run, hit_total} !== '0)
      $display("FAIL mid_reset got v=%0b ch=%0d hit=%0b run=%0d tot=%0d want all 0",
               det_valid, det_ch, det_hit, det_run, hit_total);
    else passed++;
    tick(4'b0010, 4'b0010, '0, 1'b1, rr, g);
    checks++;
    if (det_ch !== 2'd1 || det_run !== 2'd1)
      $display("FAIL post_reset_run got ch=%0d run=%0d want ch=1 run=1", det_ch, det_run);
    else passed++;
  endtask

  task automatic test_rr_pointer();
    logic [NCH-1:0] rr;
    int g;
    do_reset();
    tick(4'b0010, 4'b0000, '0, 1'b1, rr, g);
    tick(4'b1010, 4'b1010, '0, 1'b1, rr, g);
    checks++;
    if (rr !== 4'b1000 || det_ch !== 2'd3)
      $display("FAIL ptr_first got rr=%b ch=%0d want rr=1000 ch=3", rr, det_ch);
    else passed++;
    tick(4'b1010, 4'b1010, '0, 1'b1, rr, g);
    checks++;
    if (rr !== 4'b0010 || det_ch !== 2'd1)
      $display("FAIL ptr_second got rr=%b ch=%0d want rr=0010 ch=1", rr, det_ch);
    else passed++;
  endtask

  task automatic test_random();
    logic [NCH-1:0] rr, v, b, c;
    logic rdy;
    int g;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v   = NCH'($urandom);
      b   = NCH'($urandom_range(0, 15) | $urandom_range(0, 15));
      c   = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      rdy = ($urandom_range(0, 3) != 0);
      tick(v, b, c, rdy, rr, g);
      checks++;
      if (rr !== oh(g)) $display("FAIL rand_grant[%0d] got %b want %b", i, rr, oh(g));
      else passed++;
      checks++;
      if (det_valid !== m_dv || (m_dv && (det_ch !== 2'(m_ch) || det_run !== 2'(m_rout) || det_hit !== m_hit)))
        $display("FAIL rand_result[%0d] got v=%0b ch=%0d run=%0d hit=%0b want v=%0b ch=%0d run=%0d hit=%0b",
                 i, det_valid, det_ch, det_run, det_hit, m_dv, m_ch, m_rout, m_hit);
      else passed++;
      checks++;
      if (hit_total !== HCNT_W'(m_tot)) $display("FAIL rand_hit_total[%0d] got %0d want %0d", i, hit_total, m_tot);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_bit = '0; ctx_clr = '0; det_ready = 1'b1;
    m_reset();
    #1;
    test_reset();
    test_single_run();
    test_interleave();
    test_backpressure();
    test_ctx_clr();
    test_mid_reset();
    test_rr_pointer();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
